// File: rtl/mhd_pkg.sv
// Shared definitions for the Hamming-distance miter error monitor:
// FSM state encoding, default counter width and the saturation value.
package mhd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REPORT = 2'd2
    } state_e;

    localparam int CNT_W_DEF = 16;

    localparam logic [CNT_W_DEF-1:0] SAT_MAX = '1;

endpackage

// File: rtl/mhd_err_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear. count_next exposes the value
// the counter takes at the next edge so the owner can decide on it early.
module sat_counter
    import mhd_pkg::*;
#(
    parameter int W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic [W-1:0] count_next
);

    localparam logic [W-1:0] MAX_VAL = {W{1'b1}};

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Clear wins over enable so a new run always starts from zero.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != MAX_VAL)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count      = count_q;
    assign count_next = count_d;

endmodule

// File: rtl/mhd_err_monitor.sv
// Consumes the miter violation flag stream for a programmed run of N samples,
// counts violations, records the first failing index and reports pass/fail.
module mhd_err_monitor
    import mhd_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter bit EARLY_STOP = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic [CNT_W-1:0] max_err,
    input  logic             in_valid,
    input  logic             in_f,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic             first_fail_vld,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [CNT_W-1:0] samples_seen
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic [CNT_W-1:0] samples_q, samples_d;
    logic             ffv_q, ffv_d;
    logic [CNT_W-1:0] ffi_q, ffi_d;
    logic             pass_q, pass_d;

    logic             accept;
    logic             err_clr;
    logic             err_en;
    logic [CNT_W-1:0] err_next;

    assign accept  = (state_q == RUN) && in_valid;
    assign err_clr = (state_q == IDLE) && start;
    assign err_en  = accept && in_f;

    sat_counter #(
        .W (CNT_W)
    ) u_err_cnt (
        .clk        (clk),
        .rst        (rst),
        .clr        (err_clr),
        .en         (err_en),
        .count      (err_count),
        .count_next (err_next)
    );

    // The verdict is taken from the post-update error count so that the
    // flag which ends the run is already included.
    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        max_d     = max_q;
        samples_d = samples_q;
        ffv_d     = ffv_q;
        ffi_d     = ffi_q;
        pass_d    = pass_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    num_d     = num_samples;
                    max_d     = max_err;
                    samples_d = '0;
                    ffv_d     = 1'b0;
                    ffi_d     = '0;
                    pass_d    = 1'b0;
                    if (num_samples == '0) begin
                        state_d = REPORT;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    samples_d = samples_q + 1'b1;
                    if (in_f && !ffv_q) begin
                        ffv_d = 1'b1;
                        ffi_d = samples_q;
                    end
                    if ((samples_d == num_q) || (EARLY_STOP && (err_next > max_q))) begin
                        state_d = REPORT;
                        pass_d  = (err_next <= max_q);
                    end
                end
            end
            REPORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            num_q     <= '0;
            max_q     <= '0;
            samples_q <= '0;
            ffv_q     <= 1'b0;
            ffi_q     <= '0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            max_q     <= max_d;
            samples_q <= samples_d;
            ffv_q     <= ffv_d;
            ffi_q     <= ffi_d;
            pass_q    <= pass_d;
        end
    end

    assign in_ready       = (state_q == RUN);
    assign busy           = (state_q != IDLE);
    assign done           = (state_q == REPORT);
    assign pass           = pass_q;
    assign first_fail_vld = ffv_q;
    assign first_fail_idx = ffi_q;
    assign samples_seen   = samples_q;

endmodule

// File: tb/tb_mhd_err_monitor.sv
// Directed, table-driven bench for mhd_err_monitor; runs an early-stop and a
// consume-all instance side by side on the same stimulus.
module tb_mhd_err_monitor;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] num_samples;
    logic [W-1:0] max_err;
    logic         in_valid;
    logic         in_f;

    logic         es_ready, es_busy, es_done, es_pass, es_ffv;
    logic [W-1:0] es_err, es_ffi, es_samples;
    logic         nes_ready, nes_busy, nes_done, nes_pass, nes_ffv;
    logic [W-1:0] nes_err, nes_ffi, nes_samples;

    int checkCount = 0;
    int passCount  = 0;

    always #5 clk = ~clk;

    mhd_err_monitor #(.CNT_W(W), .EARLY_STOP(1'b1)) dut_es (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .num_samples    (num_samples),
        .max_err        (max_err),
        .in_valid       (in_valid),
        .in_f           (in_f),
        .in_ready       (es_ready),
        .busy           (es_busy),
        .done           (es_done),
        .pass           (es_pass),
        .err_count      (es_err),
        .first_fail_vld (es_ffv),
        .first_fail_idx (es_ffi),
        .samples_seen   (es_samples)
    );

    mhd_err_monitor #(.CNT_W(W), .EARLY_STOP(1'b0)) dut_nes (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .num_samples    (num_samples),
        .max_err        (max_err),
        .in_valid       (in_valid),
        .in_f           (in_f),
        .in_ready       (nes_ready),
        .busy           (nes_busy),
        .done           (nes_done),
        .pass           (nes_pass),
        .err_count      (nes_err),
        .first_fail_vld (nes_ffv),
        .first_fail_idx (nes_ffi),
        .samples_seen   (nes_samples)
    );

    logic         useNes;
    logic         selReady, selBusy, selDone, selPass, selFfv;
    logic [W-1:0] selErr, selFfi, selSamples;

    assign selReady   = useNes ? nes_ready   : es_ready;
    assign selBusy    = useNes ? nes_busy    : es_busy;
    assign selDone    = useNes ? nes_done    : es_done;
    assign selPass    = useNes ? nes_pass    : es_pass;
    assign selFfv     = useNes ? nes_ffv     : es_ffv;
    assign selErr     = useNes ? nes_err     : es_err;
    assign selFfi     = useNes ? nes_ffi     : es_ffi;
    assign selSamples = useNes ? nes_samples : es_samples;

    typedef struct {
        string        name;
        logic         onNes;
        logic [W-1:0] n;
        logic [W-1:0] maxErr;
        logic [15:0]  flags;
        logic [15:0]  valid;
        int           len;
        int           expErr;
        int           expSamples;
        int           expFfv;
        int           expFfi;
        int           expPass;
        int           expDone;
        int           expReady;
    } vec_t;

    vec_t vecs[6];

    function automatic vec_t mkVec(input string name, input logic onNes,
                                   input int n, input int maxErr,
                                   input logic [15:0] flags, input logic [15:0] valid,
                                   input int len, input int expErr, input int expSamples,
                                   input int expFfv, input int expFfi, input int expPass,
                                   input int expDone, input int expReady);
        vec_t v;
        v.name       = name;
        v.onNes      = onNes;
        v.n          = W'(n);
        v.maxErr     = W'(maxErr);
        v.flags      = flags;
        v.valid      = valid;
        v.len        = len;
        v.expErr     = expErr;
        v.expSamples = expSamples;
        v.expFfv     = expFfv;
        v.expFfi     = expFfi;
        v.expPass    = expPass;
        v.expDone    = expDone;
        v.expReady   = expReady;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One complete run: start pulse, then one stimulus element per cycle.
    // Cycle 0 is the first cycle after the start cycle; done is expected in
    // the cycle after the last accepted flag.
    task automatic applyStimulus(input vec_t v);
        int doneCycle  = -1;
        int doneCount  = 0;
        int readyCount = 0;
        int dErr = 0, dSamples = 0, dFfv = 0, dFfi = 0, dPass = 0;
        useNes = v.onNes;
        @(negedge clk);
        start       = 1'b1;
        num_samples = v.n;
        max_err     = v.maxErr;
        in_valid    = 1'b0;
        in_f        = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 24; c++) begin
            if (selReady) readyCount++;
            if (selDone) begin
                doneCount++;
                if (doneCycle < 0) begin
                    doneCycle = c;
                    dErr      = int'(selErr);
                    dSamples  = int'(selSamples);
                    dFfv      = int'(selFfv);
                    dFfi      = int'(selFfi);
                    dPass     = int'(selPass);
                end
            end
            if (c < v.len) begin
                in_valid = v.valid[c];
                in_f     = v.flags[c];
            end else begin
                in_valid = 1'b0;
                in_f     = 1'b0;
            end
            @(negedge clk);
        end
        checkOutput({v.name, ".done_cycle"}, doneCycle, v.expDone);
        checkOutput({v.name, ".done_pulses"}, doneCount, 1);
        checkOutput({v.name, ".ready_cycles"}, readyCount, v.expReady);
        checkOutput({v.name, ".err_count"}, dErr, v.expErr);
        checkOutput({v.name, ".samples_seen"}, dSamples, v.expSamples);
        checkOutput({v.name, ".first_fail_vld"}, dFfv, v.expFfv);
        checkOutput({v.name, ".first_fail_idx"}, dFfi, v.expFfi);
        checkOutput({v.name, ".pass"}, dPass, v.expPass);
        checkOutput({v.name, ".busy_after"}, int'(selBusy), 0);
        checkOutput({v.name, ".err_held"}, int'(selErr), v.expErr);
        checkOutput({v.name, ".pass_held"}, int'(selPass), v.expPass);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".in_ready"}, int'(es_ready), 0);
        checkOutput({tag, ".busy"}, int'(es_busy), 0);
        checkOutput({tag, ".done"}, int'(es_done), 0);
        checkOutput({tag, ".pass"}, int'(es_pass), 0);
        checkOutput({tag, ".err_count"}, int'(es_err), 0);
        checkOutput({tag, ".samples_seen"}, int'(es_samples), 0);
        checkOutput({tag, ".first_fail_vld"}, int'(es_ffv), 0);
        checkOutput({tag, ".first_fail_idx"}, int'(es_ffi), 0);
        checkOutput({tag, ".nes_busy"}, int'(nes_busy), 0);
        checkOutput({tag, ".nes_samples"}, int'(nes_samples), 0);
    endtask

    initial begin
        int doneSeen;

        vecs[0] = mkVec("basic",    1'b0,  8, 2, 16'h0012, 16'h00FF,  8, 2,  8, 1, 1, 1,  8,  8);
        vecs[1] = mkVec("early",    1'b0, 10, 1, 16'h0155, 16'h03FF, 10, 2,  3, 1, 0, 0,  3,  3);
        vecs[2] = mkVec("noearly",  1'b1, 10, 1, 16'h0155, 16'h03FF, 10, 5, 10, 1, 0, 0, 10, 10);
        vecs[3] = mkVec("zero",     1'b0,  0, 3, 16'h0000, 16'h0000,  0, 0,  0, 0, 0, 1,  0,  0);
        vecs[4] = mkVec("gaps",     1'b0,  4, 5, 16'h00AE, 16'h0055,  8, 1,  4, 1, 1, 1,  7,  7);
        vecs[5] = mkVec("lastflag", 1'b0,  3, 0, 16'h0004, 16'h0007,  3, 1,  3, 1, 2, 0,  3,  3);

        useNes      = 1'b0;
        start       = 1'b0;
        num_samples = '0;
        max_err     = '0;
        in_valid    = 1'b0;
        in_f        = 1'b0;
        rst         = 1'b1;
        #1;
        checkResetValues("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i]);
        end

        $display("[TB] mid-run reset sequence");
        useNes = 1'b0;
        @(negedge clk);
        start       = 1'b1;
        num_samples = 16'd6;
        max_err     = 16'd2;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        in_f     = 1'b1;
        @(negedge clk);
        in_f = 1'b0;
        @(negedge clk);
        in_f = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_f     = 1'b0;
        checkOutput("midrun.samples_before", int'(es_samples), 3);
        checkOutput("midrun.err_before", int'(es_err), 2);
        #2;
        rst = 1'b1;
        #1;
        checkResetValues("midrun_reset");
        @(negedge clk);
        rst      = 1'b0;
        doneSeen = 0;
        for (int c = 0; c < 8; c++) begin
            if (es_done || nes_done || es_busy) doneSeen++;
            @(negedge clk);
        end
        checkOutput("midrun.no_done_after_reset", doneSeen, 0);

        vecs[0].name = "restart";
        applyStimulus(vecs[0]);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
